// File: rtl/qpu_exu_alu_pipe_if.sv
// ---------------------------------------------------------------------------
// qpu_exu_alu_pipe_if
// Bundles the request side (NUM_REQ flattened requestor lanes) and the
// response side of the shared EXU ALU pipe.
//   req_valid/req_ready  per-requestor handshake, one bit per requestor
//   req_op               4-bit op codes, requestor i in [4i+3:4i]
//   req_op1/req_op2      XLEN-bit operands, flattened the same way
//   rsp_valid/rsp_ready  result handshake
//   rsp_res/rsp_cmp      result and compare outcome
//   rsp_id/rsp_err       originating requestor and illegal-op flag
// Modports: master = requestors + response consumer, slave = the ALU pipe.
// ---------------------------------------------------------------------------
interface qpu_exu_alu_pipe_if #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*4-1:0]    req_op;
    logic [NUM_REQ*XLEN-1:0] req_op1;
    logic [NUM_REQ*XLEN-1:0] req_op2;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [XLEN-1:0]         rsp_res;
    logic                    rsp_cmp;
    logic [IDW-1:0]          rsp_id;
    logic                    rsp_err;

    modport master (
        output req_valid, req_op, req_op1, req_op2, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_cmp, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_op1, req_op2, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_cmp, rsp_id, rsp_err
    );
endinterface

// File: rtl/qpu_exu_alu_pipe.sv
// ---------------------------------------------------------------------------
// qpu_exu_alu_pipe
// Shared, two-stage pipelined EXU ALU. A round-robin arbiter picks one of
// NUM_REQ requestors per cycle; S1 registers the granted request, S2
// registers the result and drives the response. Each response carries the
// requestor id so EXU can route it back.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  qpu_exu_alu_pipe_if.slave (request lanes + response channel)
// Optional feature: define QPU_ALU_PIPE_SAT_EN to enable signed saturating
// ADDS (14) / SUBS (15); otherwise those op codes report rsp_err.
// ---------------------------------------------------------------------------
module qpu_exu_alu_pipe #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    qpu_exu_alu_pipe_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_XOR  = 4'd2,  OP_OR   = 4'd3,
        OP_AND  = 4'd4,  OP_EQ   = 4'd5,  OP_NE   = 4'd6,  OP_LT   = 4'd7,
        OP_GE   = 4'd8,  OP_LTU  = 4'd9,  OP_GEU  = 4'd10, OP_SLL  = 4'd11,
        OP_SRL  = 4'd12, OP_SRA  = 4'd13, OP_ADDS = 4'd14, OP_SUBS = 4'd15
    } op_e;

    logic [IDW-1:0]     rr;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [IDW-1:0]     rr_next;

    logic               s1_valid;
    op_e                s1_op;
    logic [XLEN-1:0]    s1_a;
    logic [XLEN-1:0]    s1_b;
    logic [IDW-1:0]     s1_id;

    logic               s2_valid;
    logic [XLEN-1:0]    s2_res;
    logic               s2_cmp;
    logic [IDW-1:0]     s2_id;
    logic               s2_err;

    logic               s2_adv;
    logic               s1_adv;
    logic               accept;

    logic [XLEN-1:0]    alu_res;
    logic               alu_cmp;
    logic               alu_err;
    logic               is_cmp;

    // A stage may load when it is empty or its content leaves this cycle.
    assign s2_adv = !s2_valid || bus.rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign accept = gnt_any && s1_adv;

    // Rotating-priority search starting at rr; the index wraps with a
    // subtract so NUM_REQ need not be a power of two.
    always_comb begin
        logic [IDW:0] idx;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (!gnt_any && bus.req_valid[idx[IDW-1:0]]) begin
                gnt_any                 = 1'b1;
                gnt_idx                 = idx[IDW-1:0];
                grant[idx[IDW-1:0]]     = 1'b1;
            end
        end
    end

    assign rr_next       = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    assign bus.req_ready = rst ? '0 : (grant & {NUM_REQ{s1_adv}});

    // Compare subtracts: one extra bit so the borrow gives the outcome.
    logic [XLEN:0]   slt_diff;
    logic [XLEN:0]   ult_diff;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] add_sum;
    logic [XLEN-1:0] sub_diff;

    assign slt_diff = {s1_a[XLEN-1], s1_a} - {s1_b[XLEN-1], s1_b};
    assign ult_diff = {1'b0, s1_a} - {1'b0, s1_b};
    assign shamt    = s1_b[SHW-1:0];
    assign add_sum  = s1_a + s1_b;
    assign sub_diff = s1_a - s1_b;

`ifdef QPU_ALU_PIPE_SAT_EN
    // Signed overflow always saturates toward the sign of op1.
    logic            adds_ovf;
    logic            subs_ovf;
    logic [XLEN-1:0] sat_val;
    assign adds_ovf = (s1_a[XLEN-1] == s1_b[XLEN-1]) && (add_sum[XLEN-1] != s1_a[XLEN-1]);
    assign subs_ovf = (s1_a[XLEN-1] != s1_b[XLEN-1]) && (sub_diff[XLEN-1] != s1_a[XLEN-1]);
    assign sat_val  = s1_a[XLEN-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
`endif

    // Result of the op held in S1; compare ops return the outcome as a
    // zero-extended result, unknown ops return zero with the error flag.
    always_comb begin
        alu_res = '0;
        alu_cmp = 1'b0;
        alu_err = 1'b0;
        is_cmp  = 1'b0;
        case (s1_op)
            OP_ADD: alu_res = add_sum;
            OP_SUB: alu_res = sub_diff;
            OP_XOR: alu_res = s1_a ^ s1_b;
            OP_OR:  alu_res = s1_a | s1_b;
            OP_AND: alu_res = s1_a & s1_b;
            OP_EQ:  begin is_cmp = 1'b1; alu_cmp = (s1_a == s1_b); end
            OP_NE:  begin is_cmp = 1'b1; alu_cmp = (s1_a != s1_b); end
            OP_LT:  begin is_cmp = 1'b1; alu_cmp = slt_diff[XLEN]; end
            OP_GE:  begin is_cmp = 1'b1; alu_cmp = !slt_diff[XLEN]; end
            OP_LTU: begin is_cmp = 1'b1; alu_cmp = ult_diff[XLEN]; end
            OP_GEU: begin is_cmp = 1'b1; alu_cmp = !ult_diff[XLEN]; end
            OP_SLL: alu_res = s1_a << shamt;
            OP_SRL: alu_res = s1_a >> shamt;
            OP_SRA: alu_res = $signed(s1_a) >>> shamt;
`ifdef QPU_ALU_PIPE_SAT_EN
            OP_ADDS: begin
                alu_cmp = adds_ovf;
                alu_res = adds_ovf ? sat_val : add_sum;
            end
            OP_SUBS: begin
                alu_cmp = subs_ovf;
                alu_res = subs_ovf ? sat_val : sub_diff;
            end
`endif
            default: alu_err = 1'b1;
        endcase
        if (is_cmp) begin
            alu_res = {{(XLEN-1){1'b0}}, alu_cmp};
        end
    end

    // Arbiter pointer and both pipeline stages. Data registers only load
    // when a valid item enters so stalled outputs stay stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr       <= '0;
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_cmp   <= 1'b0;
            s2_id    <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (accept) begin
                rr <= rr_next;
            end
            if (s1_adv) begin
                s1_valid <= gnt_any;
                if (gnt_any) begin
                    s1_op <= op_e'(bus.req_op[int'(gnt_idx)*4 +: 4]);
                    s1_a  <= bus.req_op1[int'(gnt_idx)*XLEN +: XLEN];
                    s1_b  <= bus.req_op2[int'(gnt_idx)*XLEN +: XLEN];
                    s1_id <= gnt_idx;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_res <= alu_res;
                    s2_cmp <= alu_cmp;
                    s2_id  <= s1_id;
                    s2_err <= alu_err;
                end
            end
        end
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_res   = s2_res;
    assign bus.rsp_cmp   = s2_cmp;
    assign bus.rsp_id    = s2_id;
    assign bus.rsp_err   = s2_err;
endmodule

// File: doc/qpu_exu_alu_pipe.md
Name: qpu_exu_alu_pipe

Overview:
- Parametrised, pipelined successor of the EXU ALU datapath, shared by NUM_REQ requestors (ALU, BJP, LSU, QIU, ...).
- A round-robin arbiter grants one requestor per cycle into a 2-stage valid/ready pipeline that computes arithmetic, logic, shift and compare ops.
- Each response carries the requestor id so that EXU can route it back.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- NUM_REQ, 4, number of requestors; >= 2.
- IDW, $clog2(NUM_REQ), width of the requestor id.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requestor request valid.
- req_ready  out  NUM_REQ  per-requestor accept.
- req_op  in  NUM_REQ*4  op codes, requestor i in bits [4i+3:4i].
- req_op1  in  NUM_REQ*XLEN  operand 1, flattened the same way.
- req_op2  in  NUM_REQ*XLEN  operand 2, flattened the same way.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_res  out  XLEN  result.
- rsp_cmp  out  1  compare outcome.
- rsp_id  out  IDW  index of the originating requestor.
- rsp_err  out  1  illegal op code.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Op codes:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND.
  - 5 EQ, 6 NE, 7 LT (signed), 8 GE (signed), 9 LTU, 10 GEU.
  - 11 SLL, 12 SRL, 13 SRA.
  - 14/15 see Optional Feature.
- Arithmetic rules:
  - ADD/SUB are modulo 2^XLEN.
  - Signed compares use an XLEN+1-bit sign-extended subtract; unsigned compares use a zero-extended subtract.
  - Shift amount is op2[$clog2(XLEN)-1:0]; upper op2 bits are ignored.
  - Compare ops: rsp_cmp = outcome, rsp_res = zero-extended outcome.
  - Non-compare ops: rsp_cmp = 0.
  - Illegal op: rsp_res = 0, rsp_cmp = 0, rsp_err = 1; the op still occupies the pipe and returns a response.
- Pipeline:
  - S1 holds the registered granted request (op, operands, id).
  - S2 holds the registered result and drives the rsp_* outputs.
  - s2_adv = !rsp_valid | rsp_ready.
  - s1_adv = !s1_valid | s2_adv.
  - Latency: a request accepted at edge N gives rsp_valid high after edge N+1, when there is no backpressure.
  - Throughput: 1 op/cycle.
- Arbitration:
  - Combinational round-robin over req_valid, starting at pointer rr.
  - grant is one-hot; req_ready[i] = grant[i] & s1_adv.
  - req_ready may depend on req_valid.
  - On a handshake, rr <= granted index + 1 (mod NUM_REQ). rr is unchanged otherwise.
- Handshake rules:
  - Requestors hold valid/op/operands stable until ready.
  - rsp_* outputs hold stable while rsp_valid & !rsp_ready.
  - Backpressure stalls S2, then S1, then all req_ready go low. No op is dropped or duplicated.
- Simultaneous events:
  - S2 drain and S1 refill in the same cycle is legal (full rate).
  - All requestors valid: each is served exactly once per NUM_REQ accepted ops.
- Reset values: s1_valid = 0, rsp_valid = 0, rsp_res = 0, rsp_cmp = 0, rsp_id = 0, rsp_err = 0, rr = 0.
- Reset mid-operation: in-flight ops are discarded, no response is emitted, and req_ready is 0 during the reset cycle.

Optional Feature:
- Macro: QPU_ALU_PIPE_SAT_EN.
- Defined:
  - Op 14 ADDS and op 15 SUBS are signed saturating.
  - Overflow clamps to 2^(XLEN-1)-1 or -2^(XLEN-1).
  - rsp_cmp = 1 when saturation occurred.
- Undefined: ops 14/15 are illegal (rsp_err = 1), and no saturation logic is synthesised.

Test Plan:
- Req0 ADD 0x7FFFFFFF + 1, rsp_ready = 1 -> 2 cycles later rsp_res = 0x80000000, rsp_id = 0, rsp_err = 0.
- Req1 LT op1 = 0xFFFFFFFF, op2 = 1; then LTU with the same operands -> rsp_cmp = 1 then 0; rsp_res = 1 then 0.
- Req2 SRA 0x80000000 by op2 = 0x24 (shift 4) -> rsp_res = 0xF8000000. SLL 1 by 31 -> rsp_res = 0x80000000.
- All 4 requestors valid continuously, rsp_ready = 1 -> grant order 0,1,2,3,0,..., one response per cycle.
- rsp_ready held low for 5 cycles with 3 ops queued -> rsp_* stable; req_ready = 0 once S1 and S2 are full; all 3 responses arrive in order after release.
- Op 15 with macro defined: SUBS 0x80000000 - 1 -> rsp_res = 0x80000000, rsp_cmp = 1. Without the macro -> rsp_err = 1, rsp_res = 0.
- Reset asserted with S1 and S2 full -> next cycle rsp_valid = 0, rr = 0, and no stale response appears.
